alu_frame_ctrl: RTL and testbench

- Operand sequencer and result returner for the ALU; it is the driving end of the ALU's i_data_a / i_data_b / i_op / o_data / carry_borrow interface.
- Accepts a 3-byte command frame (A, B, OP) from a byte stream, normally the UART RX path.
- Presents the registered operands to the ALU and captures the result and carry.
- Returns the result, and optionally a flags byte, on an outgoing byte stream toward UART TX.
- Sits between the serial front end and the combinational ALU in the TP1 top level.

---
 rtl/alu_frame_ctrl.sv | 117 +++++++++++
 tb/tb_alu_frame_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_frame_ctrl.sv
// Frame controller for the TP1 ALU: collects A, B, OP bytes, drives the ALU, returns the result byte.
// Define ALU_FRAME_FLAGS_EN to append a flags byte {zeros, zero, carry} after each result.
module alu_frame_ctrl #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_carry,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy
);

    localparam logic [2:0] ST_GET_A    = 3'd0;
    localparam logic [2:0] ST_GET_B    = 3'd1;
    localparam logic [2:0] ST_GET_OP   = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_SEND_RES = 3'd4;
`ifdef ALU_FRAME_FLAGS_EN
    localparam logic [2:0] ST_SEND_FLG = 3'd5;
`endif

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       carry_q;
    logic       rx_fire;
    logic       tx_fire;

    assign rx_fire = i_rx_valid & o_rx_ready;
    assign tx_fire = o_tx_valid & i_tx_ready;

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_GET_A:    if (rx_fire) state_nxt = ST_GET_B;
            ST_GET_B:    if (rx_fire) state_nxt = ST_GET_OP;
            ST_GET_OP:   if (rx_fire) state_nxt = ST_EXEC;
            ST_EXEC:     state_nxt = ST_SEND_RES;
`ifdef ALU_FRAME_FLAGS_EN
            ST_SEND_RES: if (tx_fire) state_nxt = ST_SEND_FLG;
            ST_SEND_FLG: if (tx_fire) state_nxt = ST_GET_A;
`else
            ST_SEND_RES: if (tx_fire) state_nxt = ST_GET_A;
`endif
            default:     state_nxt = ST_GET_A;
        endcase
    end

`ifdef ALU_FRAME_FLAGS_EN
    // o_tx_data still holds the captured result while the result byte is being sent.
    logic [NB_DATA-1:0] flags_byte;
    always_comb begin
        flags_byte    = '0;
        flags_byte[1] = (o_tx_data == '0);
        flags_byte[0] = carry_q;
    end
`else
    logic unused_carry;
    assign unused_carry = carry_q;
`endif

    // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_GET_A;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_rx_ready <= 1'b1;
            carry_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            // Ready and busy are registered from the next state so they line up with it.
            o_rx_ready <= (state_nxt == ST_GET_A) || (state_nxt == ST_GET_B) ||
                          (state_nxt == ST_GET_OP);
            o_busy     <= (state_nxt != ST_GET_A);

            case (state)
                ST_GET_A:  if (rx_fire) o_alu_a <= i_rx_data;
                ST_GET_B:  if (rx_fire) o_alu_b <= i_rx_data;
                ST_GET_OP: if (rx_fire) o_alu_op <= i_rx_data[NB_OP-1:0];
                ST_EXEC: begin
                    o_tx_data  <= i_alu_result;
                    carry_q    <= i_alu_carry;
                    o_tx_valid <= 1'b1;
                end
                ST_SEND_RES: begin
                    if (tx_fire) begin
`ifdef ALU_FRAME_FLAGS_EN
                        o_tx_data <= flags_byte;
`else
                        o_tx_valid <= 1'b0;
`endif
                    end
                end
`ifdef ALU_FRAME_FLAGS_EN
                ST_SEND_FLG: if (tx_fire) o_tx_valid <= 1'b0;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Bench for alu_frame_ctrl: vector table, hand-written corner sequences, random back-to-back frames.
// Acts as the ALU itself; honours ALU_FRAME_FLAGS_EN the same way the design does.
module tb_alu_frame_ctrl;

    logic       i_clk;
    logic       i_rst_n;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       o_rx_ready;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic [7:0] i_alu_result;
    logic       i_alu_carry;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;
    logic       o_busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_frame_ctrl #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_rx_ready   (o_rx_ready),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_op     (o_alu_op),
        .i_alu_result (i_alu_result),
        .i_alu_carry  (i_alu_carry),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // TP1 ALU behaviour: returns {carry_borrow, result}.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        logic [8:0] r;
        case (op)
            6'h20: r = {1'b0, a} + {1'b0, b};
            6'h22: r = {(a < b), a - b};
            6'h24: r = {1'b0, a & b};
            6'h25: r = {1'b0, a | b};
            6'h26: r = {1'b0, a ^ b};
            6'h27: r = {1'b0, ~(a | b)};
            6'h03: r = {1'b0, 8'($signed(a) >>> b)};
            6'h02: r = {1'b0, a >> b};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb {i_alu_carry, i_alu_result} = alu_ref(o_alu_a, o_alu_b, o_alu_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offers one RX byte and returns #1 after the edge on which it transferred.
    task automatic put_byte(input logic [7:0] d, input bit drop_valid);
        int n = 0;
        i_rx_data  = d;
        i_rx_valid = 1'b1;
        while (!o_rx_ready && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (n >= 50) check("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge i_clk); #1;
        if (drop_valid) i_rx_valid = 1'b0;
    endtask

    // Waits for a TX byte (i_tx_ready must already be 1) and returns after it transferred.
    task automatic get_byte(output logic [7:0] d);
        int n = 0;
        while (!o_tx_valid && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (n >= 50) check("tx_valid_timeout", 32'd0, 32'd1);
        d = o_tx_data;
        @(posedge i_clk); #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rx_ready"}, 32'(o_rx_ready), 32'd1);
        check({tag, "_busy"},     32'(o_busy),     32'd0);
        check({tag, "_tx_valid"}, 32'(o_tx_valid), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_idle(tag);
        check({tag, "_alu_a"},   32'(o_alu_a),   32'd0);
        check({tag, "_alu_b"},   32'(o_alu_b),   32'd0);
        check({tag, "_alu_op"},  32'(o_alu_op),  32'd0);
        check({tag, "_tx_data"}, 32'(o_tx_data), 32'd0);
    endtask

    // Full frame with i_tx_ready=1, checking operands, 2-cycle latency and the response bytes.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                             input logic [5:0] exp_op, input logic [7:0] exp_res,
                             input logic [7:0] exp_flg);
        i_tx_ready = 1'b1;
        put_byte(a, 1'b0);
        put_byte(b, 1'b0);
        put_byte(opb, 1'b1);
        check("alu_a", 32'(o_alu_a), 32'(a));
        check("alu_b", 32'(o_alu_b), 32'(b));
        check("alu_op", 32'(o_alu_op), 32'(exp_op));
        check("exec_tx_valid", 32'(o_tx_valid), 32'd0);
        check("exec_rx_ready", 32'(o_rx_ready), 32'd0);
        check("exec_busy", 32'(o_busy), 32'd1);
        @(posedge i_clk); #1;
        check("latency_tx_valid", 32'(o_tx_valid), 32'd1);
        check("result", 32'(o_tx_data), 32'(exp_res));
        @(posedge i_clk); #1;
`ifdef ALU_FRAME_FLAGS_EN
        check("flags_valid", 32'(o_tx_valid), 32'd1);
        check("flags", 32'(o_tx_data), 32'(exp_flg));
        check("flags_busy", 32'(o_busy), 32'd1);
        @(posedge i_clk); #1;
`else
        check("flags_unused", 32'(exp_flg & 8'hFC), 32'd0);
`endif
        check_idle("post_frame");
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [5:0] op;
        logic [7:0] res;
        logic [7:0] flg;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] d;
        logic [7:0] stream[$];
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];

        vecs[0] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00, 8'h03};
        vecs[1] = '{8'h03, 8'h05, 8'h22, 6'h22, 8'hFE, 8'h01};
        vecs[2] = '{8'hF0, 8'h3C, 8'hA4, 6'h24, 8'h30, 8'h00};
        vecs[3] = '{8'h0F, 8'h0F, 8'h26, 6'h26, 8'h00, 8'h02};
        vecs[4] = '{8'h81, 8'h01, 8'h03, 6'h03, 8'hC0, 8'h00};
        vecs[5] = '{8'h55, 8'hAA, 8'h65, 6'h25, 8'hFF, 8'h00};
        vecs[6] = '{8'h00, 8'h00, 8'hE7, 6'h27, 8'hFF, 8'h00};
        vecs[7] = '{8'h80, 8'h80, 8'h20, 6'h20, 8'h00, 8'h03};

        i_rst_n    = 1'b0;
        i_rx_data  = '0;
        i_rx_valid = 1'b0;
        i_tx_ready = 1'b1;
        #12;
        check_reset_vals("reset");
        #5 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check_reset_vals("after_reset");

        for (int i = 0; i < 8; i++)
            run_frame(vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].op, vecs[i].res, vecs[i].flg);

        // TX backpressure with the next A byte already offered.
        i_tx_ready = 1'b0;
        put_byte(8'h11, 1'b0);
        put_byte(8'h22, 1'b0);
        put_byte(8'h20, 1'b0);
        i_rx_data  = 8'h55;
        i_rx_valid = 1'b1;
        @(posedge i_clk); #1;
        for (int i = 0; i < 6; i++) begin
            check("stall_tx_valid", 32'(o_tx_valid), 32'd1);
            check("stall_tx_data", 32'(o_tx_data), 32'h33);
            check("stall_rx_ready", 32'(o_rx_ready), 32'd0);
            check("stall_alu_a", 32'(o_alu_a), 32'h11);
            @(posedge i_clk); #1;
        end
        i_tx_ready = 1'b1;
        @(posedge i_clk); #1;
`ifdef ALU_FRAME_FLAGS_EN
        check("stall_flags", 32'(o_tx_data), 32'h00);
        @(posedge i_clk); #1;
`endif
        check("resume_rx_ready", 32'(o_rx_ready), 32'd1);
        check("resume_alu_a_held", 32'(o_alu_a), 32'h11);
        @(posedge i_clk); #1;
        check("held_byte_taken_as_a", 32'(o_alu_a), 32'h55);
        put_byte(8'h01, 1'b0);
        put_byte(8'h20, 1'b1);
        get_byte(d);
        check("held_frame_result", 32'(d), 32'h56);
`ifdef ALU_FRAME_FLAGS_EN
        get_byte(d);
        check("held_frame_flags", 32'(d), 32'h00);
`endif

        // Reset mid-frame after A and B.
        put_byte(8'h10, 1'b0);
        put_byte(8'h20, 1'b1);
        #2 i_rst_n = 1'b0;
        #1;
        check_reset_vals("midframe_reset");
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        run_frame(8'h01, 8'h02, 8'h20, 6'h20, 8'h03, 8'h00);

        // Reset while a TX byte is pending.
        i_tx_ready = 1'b0;
        put_byte(8'h44, 1'b0);
        put_byte(8'h55, 1'b0);
        put_byte(8'h20, 1'b1);
        @(posedge i_clk); #1;
        check("pending_tx_valid", 32'(o_tx_valid), 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check_reset_vals("midsend_reset");
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Random back-to-back frames with i_rx_valid held high and random TX backpressure.
        for (int f = 0; f < 24; f++) begin
            logic [7:0] a, b, opb;
            logic [8:0] r;
            logic [5:0] ops[8];
            ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
            a   = 8'($urandom);
            b   = 8'($urandom);
            opb = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
            stream.push_back(a);
            stream.push_back(b);
            stream.push_back(opb);
            r = alu_ref(a, b, opb[5:0]);
            exp_q.push_back(r[7:0]);
`ifdef ALU_FRAME_FLAGS_EN
            exp_q.push_back({6'b0, (r[7:0] == 8'h00), r[8]});
`endif
        end

        fork
            begin : producer
                int idx = 0;
                int cyc = 0;
                bit rdy;
                while (idx < stream.size() && cyc < 4000) begin
                    i_rx_data  = stream[idx];
                    i_rx_valid = 1'b1;
                    rdy = o_rx_ready;
                    @(posedge i_clk); #1;
                    if (rdy) idx++;
                    cyc++;
                end
                i_rx_valid = 1'b0;
                if (idx < stream.size()) check("producer_timeout", 32'(idx), 32'(stream.size()));
            end
            begin : consumer
                int cyc = 0;
                bit v, rd, stalled;
                logic [7:0] dd, prev_d;
                stalled = 1'b0;
                prev_d  = '0;
                while (got_q.size() < exp_q.size() && cyc < 4000) begin
                    rd = 1'($urandom_range(0, 1));
                    i_tx_ready = rd;
                    v  = o_tx_valid;
                    dd = o_tx_data;
                    if (stalled) begin
                        check("rand_stall_valid", 32'(v), 32'd1);
                        check("rand_stall_data", 32'(dd), 32'(prev_d));
                    end
                    stalled = v && !rd;
                    prev_d  = dd;
                    @(posedge i_clk); #1;
                    if (v && rd) got_q.push_back(dd);
                    cyc++;
                end
                i_tx_ready = 1'b1;
            end
        join

        check("rand_byte_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rand_byte_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        @(posedge i_clk); #1;
        check_idle("rand_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
